// File: rtl/bn_pkg.sv
// bn_pkg: shared FSM states and fixed-point types for the batch-norm scheduler.
package bn_pkg;
  localparam int IL = 4;
  localparam int FL = 16;
  localparam int W = IL + FL;
  typedef logic signed [W-1:0] fx_t;
  localparam fx_t ONE_FX = fx_t'(1) << FL;
  typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT, DRAIN, NEXT} state_t;
endpackage

// File: rtl/bn_param_table.sv
// bn_param_table: per-channel gamma/beta register file, one write port and one combinational read port.
module bn_param_table #(
  parameter int NCH = 8,
  parameter int W = 20,
  parameter int FL = 16,
  parameter int CW = $clog2(NCH)
) (
  input  logic          clk,
  input  logic          i_rst_n,
  input  logic          i_we,
  input  logic [CW-1:0] i_waddr,
  input  logic [W-1:0]  i_wgamma,
  input  logic [W-1:0]  i_wbeta,
  input  logic [CW-1:0] i_raddr,
  output logic [W-1:0]  o_gamma,
  output logic [W-1:0]  o_beta
);
  localparam logic [W-1:0] ONE = W'(1) << FL;
  logic [W-1:0] r_gamma [NCH];
  logic [W-1:0] r_beta [NCH];
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        r_gamma[i] <= ONE;
        r_beta[i] <= '0;
      end
    end else if (i_we) begin
      r_gamma[i_waddr] <= i_wgamma;
      r_beta[i_waddr] <= i_wbeta;
    end
  end
  assign o_gamma = r_gamma[i_raddr];
  assign o_beta = r_beta[i_raddr];
endmodule

// File: rtl/bn_scheduler.sv
// bn_scheduler: sequences per-channel batch-norm forward jobs and keeps per-channel statistics.
// BN_RUNNING_STATS_EN selects momentum-averaged statistics instead of plain overwrite.
module bn_scheduler
  import bn_pkg::*;
#(
  parameter int IL = 4,
  parameter int FL = 16,
  parameter int NCH = 8,
  parameter int SIZE = 16,
  parameter int MOM_SH = 3,
  localparam int W = IL + FL,
  localparam int CW = $clog2(NCH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cfg_we,
  input  logic [CW-1:0] cfg_addr,
  input  logic [W-1:0]  cfg_gamma,
  input  logic [W-1:0]  cfg_beta,
  input  logic          start,
  input  logic [CW:0]   num_ch,
  input  logic [4:0]    num,
  output logic          busy,
  output logic          job_done,
  input  logic          ch_valid,
  output logic          ch_pop,
  output logic [CW-1:0] cur_ch,
  output logic          fwd_input_ready,
  output logic [W-1:0]  fwd_gamma,
  output logic [W-1:0]  fwd_beta,
  output logic [4:0]    fwd_num,
  input  logic          fwd_done,
  input  logic [W-1:0]  fwd_mu,
  input  logic [W-1:0]  fwd_vari,
  output logic          fwd_output_taken,
  output logic          res_valid,
  input  logic          res_ready,
  input  logic [CW-1:0] stat_addr,
  output logic [W-1:0]  stat_mu,
  output logic [W-1:0]  stat_vari
);
  state_t r_state, w_next;
  logic [CW:0] r_num_ch, w_nch;
  logic [4:0] r_num, w_num, r_fnum;
  logic [CW-1:0] r_ch;
  logic r_zero_done, w_zero, w_last, w_cap;
  logic [W-1:0] r_gamma, r_beta, w_gamma, w_beta;
  logic [W-1:0] r_mu [NCH];
  logic [W-1:0] r_vari [NCH];

  bn_param_table #(.NCH(NCH), .W(W), .FL(FL), .CW(CW)) u_table (
    .clk(clk), .i_rst_n(reset), .i_we(cfg_we), .i_waddr(cfg_addr),
    .i_wgamma(cfg_gamma), .i_wbeta(cfg_beta), .i_raddr(r_ch),
    .o_gamma(w_gamma), .o_beta(w_beta)
  );

  assign w_nch = (num_ch > (CW+1)'(NCH)) ? (CW+1)'(NCH) : num_ch;
  assign w_num = (num > 5'(SIZE)) ? 5'(SIZE) : num;
  assign w_zero = (w_nch == '0) || (w_num == '0);
  assign w_last = {1'b0, r_ch} == r_num_ch - 1'b1;
  assign w_cap = (r_state == WAIT) && fwd_done;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    w_next = (start && !w_zero) ? FETCH : IDLE;
      FETCH:   w_next = ch_valid ? ISSUE : FETCH;
      ISSUE:   w_next = WAIT;
      WAIT:    w_next = fwd_done ? DRAIN : WAIT;
      DRAIN:   w_next = res_ready ? NEXT : DRAIN;
      NEXT:    w_next = w_last ? IDLE : FETCH;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else r_state <= w_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_num_ch <= '0;
      r_num <= '0;
      r_ch <= '0;
      r_zero_done <= 1'b0;
      r_gamma <= '0;
      r_beta <= '0;
      r_fnum <= '0;
    end else begin
      r_zero_done <= (r_state == IDLE) && start && w_zero;
      if (r_state == IDLE && start) begin
        r_num_ch <= w_nch;
        r_num <= w_num;
        r_ch <= '0;
      end
      // Parameters are frozen on entry to ISSUE so later table writes cannot disturb the running channel.
      if (r_state == FETCH && ch_valid) begin
        r_gamma <= w_gamma;
        r_beta <= w_beta;
        r_fnum <= r_num;
      end
      if (r_state == NEXT && !w_last) r_ch <= r_ch + 1'b1;
    end
  end

`ifdef BN_RUNNING_STATS_EN
  logic signed [W-1:0] w_dmu, w_dvari, w_smu, w_svari;
  assign w_dmu = fwd_mu - r_mu[r_ch];
  assign w_dvari = fwd_vari - r_vari[r_ch];
  // Shift kept in its own signed net so it stays arithmetic inside the unsigned add.
  assign w_smu = w_dmu >>> MOM_SH;
  assign w_svari = w_dvari >>> MOM_SH;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NCH; i++) begin
        r_mu[i] <= '0;
        r_vari[i] <= '0;
      end
    end else if (w_cap) begin
`ifdef BN_RUNNING_STATS_EN
      r_mu[r_ch] <= r_mu[r_ch] + w_smu;
      r_vari[r_ch] <= r_vari[r_ch] + w_svari;
`else
      r_mu[r_ch] <= fwd_mu;
      r_vari[r_ch] <= fwd_vari;
`endif
    end
  end

  assign busy = r_state != IDLE;
  assign job_done = r_zero_done || (r_state == NEXT && w_last);
  assign fwd_input_ready = r_state == ISSUE;
  assign ch_pop = r_state == ISSUE;
  assign res_valid = r_state == DRAIN;
  assign fwd_output_taken = r_state == NEXT;
  assign cur_ch = r_ch;
  assign fwd_gamma = r_gamma;
  assign fwd_beta = r_beta;
  assign fwd_num = r_fnum;
  assign stat_mu = r_mu[stat_addr];
  assign stat_vari = r_vari[stat_addr];
endmodule

// File: tb/tb_bn_scheduler.sv
// tb_bn_scheduler: directed jobs against a channel-level model of the scheduler and its statistics.
module tb_bn_scheduler;
  localparam int W = 20, CW = 3, NCH = 8, SIZE = 16;
  logic clk = 0, reset = 0, cfg_we = 0, start = 0, ch_valid = 0, fwd_done = 0, res_ready = 0;
  logic [CW-1:0] cfg_addr = 0, stat_addr = 0;
  logic [W-1:0] cfg_gamma = 0, cfg_beta = 0, fwd_mu = 0, fwd_vari = 0;
  logic [CW:0] num_ch = 0;
  logic [4:0] num = 0;
  logic busy, job_done, ch_pop, fwd_input_ready, fwd_output_taken, res_valid;
  logic [CW-1:0] cur_ch;
  logic [W-1:0] fwd_gamma, fwd_beta, stat_mu, stat_vari;
  logic [4:0] fwd_num;
  int n_cmp = 0, n_fail = 0;
  logic [W-1:0] m_gamma [NCH], m_beta [NCH], m_mu [NCH], m_vari [NCH];
  int c_iss, c_take, c_done, c_pop;
  logic [4:0] e_num;
  logic [W-1:0] e_g, g0, b0;
  logic [4:0] n0;

  bn_scheduler dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_gamma(cfg_gamma),
    .cfg_beta(cfg_beta), .start(start), .num_ch(num_ch), .num(num), .busy(busy),
    .job_done(job_done), .ch_valid(ch_valid), .ch_pop(ch_pop), .cur_ch(cur_ch),
    .fwd_input_ready(fwd_input_ready), .fwd_gamma(fwd_gamma), .fwd_beta(fwd_beta),
    .fwd_num(fwd_num), .fwd_done(fwd_done), .fwd_mu(fwd_mu), .fwd_vari(fwd_vari),
    .fwd_output_taken(fwd_output_taken), .res_valid(res_valid), .res_ready(res_ready),
    .stat_addr(stat_addr), .stat_mu(stat_mu), .stat_vari(stat_vari)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_gamma[i] = 20'h10000;
      m_beta[i] = 0;
      m_mu[i] = 0;
      m_vari[i] = 0;
    end
  endtask

  task automatic model_capture(input int k, input logic [W-1:0] mu, input logic [W-1:0] vr);
    logic signed [W-1:0] d;
`ifdef BN_RUNNING_STATS_EN
    d = mu - m_mu[k];
    d = d >>> 3;
    m_mu[k] = m_mu[k] + d;
    d = vr - m_vari[k];
    d = d >>> 3;
    m_vari[k] = m_vari[k] + d;
`else
    d = 0;
    m_mu[k] = mu + d;
    m_vari[k] = vr;
`endif
  endtask

  always @(negedge clk) if (reset) begin
    if (fwd_input_ready) begin
      chk("issue_ch", cur_ch, c_iss);
      chk("issue_gamma", fwd_gamma, m_gamma[c_iss]);
      chk("issue_beta", fwd_beta, m_beta[c_iss]);
      chk("issue_num", fwd_num, e_num);
      e_g = m_gamma[c_iss];
      c_iss++;
    end
    if (res_valid) chk("held_gamma", fwd_gamma, e_g);
    if (ch_pop) c_pop++;
    if (fwd_output_taken) c_take++;
    if (job_done) c_done++;
  end

  task automatic cfg(input int a, input logic [W-1:0] g, input logic [W-1:0] b);
    cfg_we = 1; cfg_addr = CW'(a); cfg_gamma = g; cfg_beta = b;
    @(posedge clk) #1 cfg_we = 0;
    m_gamma[a] = g;
    m_beta[a] = b;
  endtask

  task automatic check_stats();
    for (int i = 0; i < NCH; i++) begin
      stat_addr = CW'(i);
      #1;
      chk("stat_mu", stat_mu, m_mu[i]);
      chk("stat_vari", stat_vari, m_vari[i]);
    end
  endtask

  task automatic run_job(input int nch, input int nm, input int dd, input int rr,
                         input int cfg_k, input int abort_k, input logic [W-1:0] mu0);
    int en, ok, t;
    en = nch > NCH ? NCH : nch;
    e_num = 5'(nm > SIZE ? SIZE : nm);
    c_iss = 0; c_take = 0; c_done = 0; c_pop = 0;
    num_ch = (CW+1)'(nch); num = 5'(nm); start = 1;
    @(posedge clk) #1 start = 0;
    if (en == 0 || nm == 0) begin
      chk("zero_done", job_done, 1);
      chk("zero_busy", busy, 0);
      @(posedge clk) #1 chk("zero_done_clr", job_done, 0);
      repeat (3) @(posedge clk);
      #1 chk("zero_issues", c_iss, 0);
      chk("zero_pops", c_pop, 0);
      chk("zero_done_cnt", c_done, 1);
      return;
    end
    chk("lat_early", fwd_input_ready, 0);
    for (int k = 0; k < en; k++) begin
      ok = 0;
      for (t = 0; t < 100; t++) begin
        if (fwd_input_ready) begin ok = 1; break; end
        @(posedge clk) #1;
      end
      chk("issue_seen", ok, 1);
      if (!ok) return;
      if (k == 0) chk("issue_latency", t, 1);
      if (k == 0) begin g0 = fwd_gamma; b0 = fwd_beta; n0 = fwd_num; end
      if (k == cfg_k) begin
        cfg_we = 1; cfg_addr = CW'(k); cfg_gamma = m_gamma[k] + 7; cfg_beta = m_beta[k];
      end
      @(posedge clk) #1;
      if (cfg_we) begin
        cfg_we = 0; m_gamma[k] = cfg_gamma;
        start = 1; num_ch = 1; num = 1;
        @(posedge clk) #1 start = 0;
      end
      repeat (dd - 1) @(posedge clk) #1;
      if (k == cfg_k) repeat (0) @(posedge clk);
      fwd_done = 1; fwd_mu = mu0 + W'(16 * k); fwd_vari = W'(40 + k);
      if (k == abort_k) begin
        reset = 0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_ready", fwd_input_ready, 0);
        chk("rst_pop", ch_pop, 0);
        chk("rst_resv", res_valid, 0);
        chk("rst_taken", fwd_output_taken, 0);
        chk("rst_done", job_done, 0);
        chk("rst_ch", cur_ch, 0);
        chk("rst_gamma", fwd_gamma, 0);
        chk("rst_num", fwd_num, 0);
        @(posedge clk) #1 fwd_done = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1;
        @(posedge clk) #1;
        chk("rel_busy", busy, 0);
        chk("rel_ready", fwd_input_ready, 0);
        return;
      end
      @(posedge clk) #1 fwd_done = 0;
      model_capture(k, fwd_mu, fwd_vari);
      chk("drain_valid", res_valid, 1);
      repeat (rr) @(posedge clk) #1;
      res_ready = 1;
      @(posedge clk) #1 res_ready = 0;
      chk("taken", fwd_output_taken, 1);
      chk("done_at_next", job_done, k == en - 1);
      @(posedge clk) #1;
      if (dd > 5 && k < en - 1) begin
        ch_valid = 0;
        repeat (3) @(posedge clk) #1;
        chk("fetch_hold", fwd_input_ready, 0);
        ch_valid = 1;
      end
    end
    chk("end_busy", busy, 0);
    chk("issue_cnt", c_iss, en);
    chk("pop_cnt", c_pop, en);
    chk("take_cnt", c_take, en);
    chk("done_cnt", c_done, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1;
    chk("init_busy", busy, 0);
    chk("init_done", job_done, 0);
    chk("init_gamma", fwd_gamma, 0);
    check_stats();
    ch_valid = 1;
    cfg(0, 2, 5);
    run_job(1, 10, 3, 2, -1, -1, 80);
    chk("lit_gamma", g0, 2);
    chk("lit_beta", b0, 5);
    chk("lit_num", n0, 10);
    stat_addr = 0;
    #1;
`ifdef BN_RUNNING_STATS_EN
    chk("lit_mu1", stat_mu, 10);
`else
    chk("lit_mu1", stat_mu, 80);
`endif
    run_job(1, 10, 2, 0, -1, -1, 80);
    stat_addr = 0;
    #1;
`ifdef BN_RUNNING_STATS_EN
    chk("lit_mu2", stat_mu, 18);
`else
    chk("lit_mu2", stat_mu, 80);
`endif
    check_stats();
    cfg(1, 20'h18000, 20'hFFFF0);
    cfg(2, 20'h08000, 20'h00100);
    run_job(3, 20, 20, 4, 1, -1, 20'hFFF60);
    check_stats();
    run_job(0, 5, 1, 0, -1, -1, 0);
    run_job(2, 0, 1, 0, -1, -1, 0);
    run_job(12, 3, 1, 0, -1, -1, 200);
    check_stats();
    cfg(1, 20'h20000, 20'h00033);
    run_job(3, 4, 3, 1, -1, 1, 500);
    check_stats();
    run_job(2, 7, 2, 1, -1, -1, 64);
    check_stats();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
